// File: rtl/alu_exec_pkg.sv
// Shared types for the bit-serial ALU execution unit: opcodes, FSM states, opcode width.
package alu_exec_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational one-bit ALU slice; illegal opcodes yield ri=0, co=0.
module alu_bit_slice
   import alu_exec_pkg::*;
(
   input  logic            ai,
   input  logic            bi,
   input  logic            ci,
   input  logic [OP_W-1:0] op,
   output logic            ri,
   output logic            co
);

   logic b_eff;

   always_comb begin
      ri    = 1'b0;
      co    = 1'b0;
      // SUB is a + ~b + 1; the +1 arrives as the initial carry.
      b_eff = (op == OP_SUB) ? ~bi : bi;
      case (op)
         OP_AND: ri = ai & bi;
         OP_OR:  ri = ai | bi;
         OP_XOR: ri = ai ^ bi;
         OP_ADD, OP_SUB: begin
            ri = ai ^ b_eff ^ ci;
            co = (ai & b_eff) | (ai & ci) | (b_eff & ci);
         end
         default: begin
            ri = 1'b0;
            co = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_exec.sv
// Bit-serial ALU: one result bit per clock, LSB first, with registered Z/N/C/V flags.
// Optional feature macro: ALU_EXEC_CV_FLAGS_EN enables carry/overflow flag capture.
module alu_serial_exec
   import alu_exec_pkg::*;
#(
   parameter int N = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic            busy,
   output logic            done,
   output logic [N-1:0]    result,
   output logic            flagZ,
   output logic            flagN,
   output logic            flagC,
   output logic            flagV
);

   localparam int CW = $clog2(N);

   // Handshake: start is accepted only in IDLE; busy covers LOAD and SHIFT;
   // done pulses for the single DONE cycle, when result/flags are already valid.
   state_e          state, state_nxt;
   logic [N-1:0]    sh_a, sh_b, acc, acc_nxt;
   logic [OP_W-1:0] op_q;
   logic [CW-1:0]   cnt;
   logic            carry, ri, co, last;

   alu_bit_slice u_slice (
      .ai (sh_a[0]),
      .bi (sh_b[0]),
      .ci (carry),
      .op (op_q),
      .ri (ri),
      .co (co)
   );

   assign last    = (cnt == CW'(N - 1));
   assign acc_nxt = {ri, acc[N-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD: begin
            busy      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_a   <= '0;
         sh_b   <= '0;
         acc    <= '0;
         op_q   <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         result <= '0;
         flagZ  <= 1'b0;
         flagN  <= 1'b0;
         flagC  <= 1'b0;
         flagV  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b;
                  op_q  <= op;
                  cnt   <= '0;
                  carry <= (op == OP_SUB);
               end
            end
            SHIFT: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               acc   <= acc_nxt;
               carry <= co;
               cnt   <= cnt + 1'b1;
               // Outputs are captured on the final bit so they are valid during DONE.
               if (last) begin
                  result <= acc_nxt;
                  flagZ  <= (acc_nxt == '0);
                  flagN  <= acc_nxt[N-1];
`ifdef ALU_EXEC_CV_FLAGS_EN
                  flagC  <= is_arith(op_q) & co;
                  flagV  <= is_arith(op_q) & (carry ^ co);
`else
                  flagC  <= 1'b0;
                  flagV  <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed table-driven bench for alu_serial_exec (N=4) plus multi-cycle corner sequences.
module tb_alu_serial_exec;

   localparam int N = 4;

   typedef struct {
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         busy, done, flag_z, flag_n, flag_c, flag_v;
   logic [N-1:0] result;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] prev_res = '0;
   logic         cv_en;
   vec_t         vecs[13];

   always #5 clk = ~clk;

   alu_serial_exec #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flagZ  (flag_z),
      .flagN  (flag_n),
      .flagC  (flag_c),
      .flagV  (flag_v)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts one operation and waits (bounded) for done; reports latency and busy/stability history.
   task automatic run_op(input logic [2:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                         output int lat, output logic busy_ok, output logic stable_ok);
      int cyc;
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 1; busy_ok = 1'b1; stable_ok = 1'b1;
      while (done !== 1'b1 && cyc < 20) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (result !== prev_res) stable_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      lat = (done === 1'b1) ? cyc : -1;
   endtask

   initial begin
      int          lat, cyc, n_done;
      logic        busy_ok, stable_ok;
      logic [N-1:0] first_res, exp_r;

`ifdef ALU_EXEC_CV_FLAGS_EN
      cv_en = 1'b1;
`else
      cv_en = 1'b0;
`endif

      //           op      a        b        res      z     n     c     v
      vecs[0]  = '{3'b000, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{3'b000, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'b011, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{3'b100, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{3'b011, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{3'b001, 4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{3'b010, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'b100, 4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{3'b100, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{3'b011, 4'b0110, 4'b0011, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{3'b110, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{3'b101, 4'b0110, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{3'b011, 4'b1001, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      check("reset_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         exp_q.push_back(vecs[i].res);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok, stable_ok);
         exp_r = exp_q.pop_front();
         check($sformatf("v%0d_latency", i), lat, 6);
         check($sformatf("v%0d_result", i), result, exp_r);
         check($sformatf("v%0d_z", i), flag_z, vecs[i].z);
         check($sformatf("v%0d_n", i), flag_n, vecs[i].n);
         check($sformatf("v%0d_c", i), flag_c, vecs[i].c & cv_en);
         check($sformatf("v%0d_v", i), flag_v, vecs[i].v & cv_en);
         check($sformatf("v%0d_busy_in_done", i), busy, 0);
         check($sformatf("v%0d_busy_held", i), busy_ok, 1);
         check($sformatf("v%0d_result_stable", i), stable_ok, 1);
         prev_res = exp_r;
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), done, 0);
      end

      // Start pulsed mid-SHIFT with new operands: ignored, single done
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 4'b1100; b = 4'b1010;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_done = 0; first_res = '0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 3) begin
            start = 1'b1; op = 3'b001; a = 4'b0011; b = 4'b0101;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            if (n_done == 0) first_res = result;
            n_done++;
         end
         @(negedge clk);
      end
      check("midshift_done_count", n_done, 1);
      check("midshift_result", first_res, 4'b1000);
      prev_res = 4'b1000;

      // Start held through DONE: ignored there, accepted in the following IDLE cycle
      run_op(3'b010, 4'b1111, 4'b0101, lat, busy_ok, stable_ok);
      check("b2b_first_result", result, 4'b1010);
      prev_res = 4'b1010;
      start = 1'b1; op = 3'b011; a = 4'b0001; b = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 2;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_latency_from_done", cyc, 7);
      check("b2b_second_result", result, 4'b0010);
      prev_res = 4'b0010;

      // Reset during SHIFT aborts with no done
      @(negedge clk);
      start = 1'b1; op = 3'b011; a = 4'b0111; b = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      rst_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      check("abort_no_done", n_done, 0);
      prev_res = '0;
      run_op(3'b110, 4'b1010, 4'b0110, lat, busy_ok, stable_ok);
      check("illegal_latency", lat, 6);
      check("illegal_result", result, 0);
      check("illegal_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
